// File: rtl/qdr_arb_pkg.sv
// Shared FSM state, read-tag encoding and data widths for the QDR port arbiter.
package qdr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_B1  = 2'd1,
    RD_GAP = 2'd2
  } arb_state_t;

  localparam logic TAG_CPU = 1'b0;
  localparam logic TAG_APP = 1'b1;

  localparam int unsigned BEAT_W  = 36;
  localparam int unsigned BURST_W = 72;

endpackage

// File: rtl/qdr_tag_fifo.sv
// In-order read-tag FIFO: 1-bit entries, full/empty flags, push and pop may coincide.
module qdr_tag_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_push_data,
  input  logic i_pop,
  output logic o_pop_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_pop_data = r_mem[r_rptr[AW-1:0]];
  assign w_push_ok  = i_push & ~o_full;
  assign w_pop_ok   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/qdr_port_arbiter.sv
// QDR command arbiter: CPU strobe port and app valid/ready port onto one BL4 QDR user interface.
// Define QDR_ARB_RR_EN for round-robin arbitration; default build is fixed CPU priority.
module qdr_port_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic                 qdr_clk_i,
  input  logic                 qdr_rst_n_i,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic                 cpu_wr_en,
  input  logic [BEAT_W-1:0]    cpu_wr_data,
  input  logic [3:0]           cpu_wr_be,
  input  logic                 cpu_rd_en,
  output logic [BEAT_W-1:0]    cpu_rd_data,
  output logic                 cpu_rd_dvld,
  input  logic                 app_cmd_valid,
  output logic                 app_cmd_ready,
  input  logic                 app_cmd_we,
  input  logic [ADDR_BITS-1:0] app_addr,
  input  logic [BURST_W-1:0]   app_wr_data,
  input  logic [7:0]           app_wr_be,
  output logic [BURST_W-1:0]   app_rd_data,
  output logic                 app_rd_dvld,
  input  logic                 phy_rdy,
  output logic [ADDR_BITS-1:0] phy_addr,
  output logic                 phy_wr_en,
  output logic [BEAT_W-1:0]    phy_wr_data,
  output logic [3:0]           phy_wr_be,
  output logic                 phy_rd_en,
  input  logic [BEAT_W-1:0]    phy_rd_data,
  input  logic                 phy_rd_dvld,
  output logic                 cpu_overflow,
  output logic                 rd_orphan,
  input  logic                 clr_flags
);

  arb_state_t             r_state, w_state_nxt;
  logic                   r_run;
  logic                   r_hold_vld, r_hold_cap, r_hold_we;
  logic [ADDR_BITS-1:0]   r_hold_addr;
  logic [BURST_W-1:0]     r_hold_data;
  logic [7:0]             r_hold_be;
  logic [BEAT_W-1:0]      r_b1_data, w_b1_data_nxt;
  logic [3:0]             r_b1_be, w_b1_be_nxt;
  logic                   r_ret_b1, r_ret_tag;
  logic [BEAT_W-1:0]      r_ret_b0;
  logic                   w_tag_full, w_tag_empty, w_tag_head;
  logic                   w_slot, w_cpu_elig, w_app_elig, w_cpu_win, w_app_win;
  logic                   w_push, w_push_tag, w_pop, w_cpu_strobe, w_hold_busy;
  logic                   w_wr_en_nxt, w_rd_en_nxt;
  logic [ADDR_BITS-1:0]   w_addr_nxt;
  logic [BEAT_W-1:0]      w_wdata_nxt;
  logic [3:0]             w_be_nxt;

  // r_run keeps the combinational ready low while reset is asserted.
  assign w_slot     = r_run & (r_state == IDLE) & phy_rdy;
  assign w_cpu_elig = r_hold_vld & (r_hold_we | ~w_tag_full);
  assign w_app_elig = app_cmd_valid & (app_cmd_we | ~w_tag_full);

`ifdef QDR_ARB_RR_EN
  logic r_rr_cpu;
  assign w_cpu_win = w_slot & w_cpu_elig & (~w_app_elig | r_rr_cpu);

  always_ff @(posedge qdr_clk_i or negedge qdr_rst_n_i) begin
    if (!qdr_rst_n_i)   r_rr_cpu <= 1'b1;
    else if (w_cpu_win) r_rr_cpu <= 1'b0;
    else if (w_app_win) r_rr_cpu <= 1'b1;
  end
`else
  assign w_cpu_win = w_slot & w_cpu_elig;
`endif

  assign app_cmd_ready = w_slot & ~w_cpu_win & (app_cmd_we | ~w_tag_full);
  assign w_app_win     = app_cmd_valid & app_cmd_ready;
  assign w_cpu_strobe  = cpu_wr_en | cpu_rd_en;
  assign w_hold_busy   = r_hold_vld | r_hold_cap;
  assign w_pop         = phy_rd_dvld & ~r_ret_b1 & ~w_tag_empty;

  qdr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .i_clk       (qdr_clk_i),
    .i_rst_n     (qdr_rst_n_i),
    .i_push      (w_push),
    .i_push_data (w_push_tag),
    .i_pop       (w_pop),
    .o_pop_data  (w_tag_head),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

  always_ff @(posedge qdr_clk_i or negedge qdr_rst_n_i) begin
    if (!qdr_rst_n_i) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_addr_nxt    = phy_addr;
    w_wdata_nxt   = phy_wr_data;
    w_be_nxt      = phy_wr_be;
    w_b1_data_nxt = r_b1_data;
    w_b1_be_nxt   = r_b1_be;
    w_push        = 1'b0;
    w_push_tag    = TAG_CPU;
    unique case (r_state)
      IDLE: begin
        if (w_cpu_win) begin
          w_addr_nxt = r_hold_addr;
          if (r_hold_we) begin
            w_wr_en_nxt   = 1'b1;
            w_wdata_nxt   = r_hold_data[BEAT_W-1:0];
            w_be_nxt      = r_hold_be[3:0];
            w_b1_data_nxt = r_hold_data[BURST_W-1:BEAT_W];
            w_b1_be_nxt   = r_hold_be[7:4];
            w_state_nxt   = WR_B1;
          end else begin
            w_rd_en_nxt = 1'b1;
            w_push      = 1'b1;
            w_state_nxt = RD_GAP;
          end
        end else if (w_app_win) begin
          w_addr_nxt = app_addr;
          if (app_cmd_we) begin
            w_wr_en_nxt   = 1'b1;
            w_wdata_nxt   = app_wr_data[BEAT_W-1:0];
            w_be_nxt      = app_wr_be[3:0];
            w_b1_data_nxt = app_wr_data[BURST_W-1:BEAT_W];
            w_b1_be_nxt   = app_wr_be[7:4];
            w_state_nxt   = WR_B1;
          end else begin
            w_rd_en_nxt = 1'b1;
            w_push      = 1'b1;
            w_push_tag  = TAG_APP;
            w_state_nxt = RD_GAP;
          end
        end
      end
      WR_B1: begin
        w_wdata_nxt = r_b1_data;
        w_be_nxt    = r_b1_be;
        w_state_nxt = IDLE;
      end
      RD_GAP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge qdr_clk_i or negedge qdr_rst_n_i) begin
    if (!qdr_rst_n_i) begin
      phy_wr_en   <= 1'b0;
      phy_rd_en   <= 1'b0;
      phy_addr    <= '0;
      phy_wr_data <= '0;
      phy_wr_be   <= '0;
      r_b1_data   <= '0;
      r_b1_be     <= '0;
    end else begin
      phy_wr_en   <= w_wr_en_nxt;
      phy_rd_en   <= w_rd_en_nxt;
      phy_addr    <= w_addr_nxt;
      phy_wr_data <= w_wdata_nxt;
      phy_wr_be   <= w_be_nxt;
      r_b1_data   <= w_b1_data_nxt;
      r_b1_be     <= w_b1_be_nxt;
    end
  end

  // CPU write beat 1 arrives the cycle after the strobe; the hold turns valid only once it lands.
  always_ff @(posedge qdr_clk_i or negedge qdr_rst_n_i) begin
    if (!qdr_rst_n_i) begin
      r_hold_vld  <= 1'b0;
      r_hold_cap  <= 1'b0;
      r_hold_we   <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_be   <= '0;
    end else begin
      if (w_cpu_win) r_hold_vld <= 1'b0;
      if (r_hold_cap) begin
        r_hold_cap                      <= 1'b0;
        r_hold_vld                      <= 1'b1;
        r_hold_data[BURST_W-1:BEAT_W]   <= cpu_wr_data;
        r_hold_be[7:4]                  <= cpu_wr_be;
      end else if (w_cpu_strobe && !w_hold_busy) begin
        r_hold_addr <= cpu_addr;
        r_hold_we   <= cpu_wr_en;
        if (cpu_wr_en) begin
          r_hold_cap                <= 1'b1;
          r_hold_data[BEAT_W-1:0]   <= cpu_wr_data;
          r_hold_be[3:0]            <= cpu_wr_be;
        end else begin
          r_hold_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge qdr_clk_i or negedge qdr_rst_n_i) begin
    if (!qdr_rst_n_i) begin
      cpu_rd_data  <= '0;
      cpu_rd_dvld  <= 1'b0;
      app_rd_data  <= '0;
      app_rd_dvld  <= 1'b0;
      r_ret_b1     <= 1'b0;
      r_ret_tag    <= TAG_CPU;
      r_ret_b0     <= '0;
      cpu_overflow <= 1'b0;
      rd_orphan    <= 1'b0;
    end else begin
      cpu_rd_dvld <= 1'b0;
      app_rd_dvld <= 1'b0;
      r_ret_b1    <= w_pop;
      if (w_pop) begin
        r_ret_tag <= w_tag_head;
        r_ret_b0  <= phy_rd_data;
        if (w_tag_head == TAG_CPU) begin
          cpu_rd_data <= phy_rd_data;
          cpu_rd_dvld <= 1'b1;
        end
      end else if (r_ret_b1) begin
        if (r_ret_tag == TAG_CPU) begin
          cpu_rd_data <= phy_rd_data;
        end else begin
          app_rd_data <= {phy_rd_data, r_ret_b0};
          app_rd_dvld <= 1'b1;
        end
      end
      if (clr_flags) begin
        cpu_overflow <= 1'b0;
        rd_orphan    <= 1'b0;
      end
      if (w_cpu_strobe && w_hold_busy)                  cpu_overflow <= 1'b1;
      if (phy_rd_dvld && !r_ret_b1 && w_tag_empty)      rd_orphan    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// Self-checking bench for qdr_port_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_qdr_port_arbiter;

  logic         clk;
  logic         qdr_rst_n_i;
  logic [21:0]  cpu_addr;
  logic         cpu_wr_en;
  logic [35:0]  cpu_wr_data;
  logic [3:0]   cpu_wr_be;
  logic         cpu_rd_en;
  logic [35:0]  cpu_rd_data;
  logic         cpu_rd_dvld;
  logic         app_cmd_valid;
  logic         app_cmd_ready;
  logic         app_cmd_we;
  logic [21:0]  app_addr;
  logic [71:0]  app_wr_data;
  logic [7:0]   app_wr_be;
  logic [71:0]  app_rd_data;
  logic         app_rd_dvld;
  logic         phy_rdy;
  logic [21:0]  phy_addr;
  logic         phy_wr_en;
  logic [35:0]  phy_wr_data;
  logic [3:0]   phy_wr_be;
  logic         phy_rd_en;
  logic [35:0]  phy_rd_data;
  logic         phy_rd_dvld;
  logic         cpu_overflow;
  logic         rd_orphan;
  logic         clr_flags;

  int checks = 0;
  int errors = 0;
  // Outstanding reads in issue order: 1 = app requester, 0 = CPU requester.
  logic q[$];

  qdr_port_arbiter #(.TAG_DEPTH(16), .ADDR_BITS(22)) dut (
    .qdr_clk_i     (clk),
    .qdr_rst_n_i   (qdr_rst_n_i),
    .cpu_addr      (cpu_addr),
    .cpu_wr_en     (cpu_wr_en),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_wr_be     (cpu_wr_be),
    .cpu_rd_en     (cpu_rd_en),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_rd_dvld   (cpu_rd_dvld),
    .app_cmd_valid (app_cmd_valid),
    .app_cmd_ready (app_cmd_ready),
    .app_cmd_we    (app_cmd_we),
    .app_addr      (app_addr),
    .app_wr_data   (app_wr_data),
    .app_wr_be     (app_wr_be),
    .app_rd_data   (app_rd_data),
    .app_rd_dvld   (app_rd_dvld),
    .phy_rdy       (phy_rdy),
    .phy_addr      (phy_addr),
    .phy_wr_en     (phy_wr_en),
    .phy_wr_data   (phy_wr_data),
    .phy_wr_be     (phy_wr_be),
    .phy_rd_en     (phy_rd_en),
    .phy_rd_data   (phy_rd_data),
    .phy_rd_dvld   (phy_rd_dvld),
    .cpu_overflow  (cpu_overflow),
    .rd_orphan     (rd_orphan),
    .clr_flags     (clr_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_phy_wr_en"},   phy_wr_en,     0);
    chk({tag, "_phy_rd_en"},   phy_rd_en,     0);
    chk({tag, "_phy_addr"},    phy_addr,      0);
    chk({tag, "_phy_wr_data"}, phy_wr_data,   0);
    chk({tag, "_phy_wr_be"},   phy_wr_be,     0);
    chk({tag, "_cpu_dvld"},    cpu_rd_dvld,   0);
    chk({tag, "_cpu_data"},    cpu_rd_data,   0);
    chk({tag, "_app_dvld"},    app_rd_dvld,   0);
    chk({tag, "_app_data"},    app_rd_data,   0);
    chk({tag, "_app_ready"},   app_cmd_ready, 0);
    chk({tag, "_overflow"},    cpu_overflow,  0);
    chk({tag, "_orphan"},      rd_orphan,     0);
  endtask

  task automatic do_reset();
    qdr_rst_n_i   = 1'b0;
    cpu_wr_en     = 1'b0;
    cpu_rd_en     = 1'b0;
    app_cmd_valid = 1'b0;
    phy_rd_dvld   = 1'b0;
    clr_flags     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    qdr_rst_n_i = 1'b1;
    q.delete();
    tick();
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [35:0] d0, input logic [35:0] d1,
                           input logic [3:0] b0, input logic [3:0] b1);
    cpu_addr = a; cpu_wr_en = 1'b1; cpu_wr_data = d0; cpu_wr_be = b0;
    tick();
    cpu_wr_en = 1'b0; cpu_wr_data = d1; cpu_wr_be = b1;
    chk("cwr_n1_idle", phy_wr_en, 0);
    tick();
    cpu_wr_data = rnd36();
    chk("cwr_n2_idle", phy_wr_en, 0);
    tick();
    chk("cwr_b0_en",   phy_wr_en,   1);
    chk("cwr_addr",    phy_addr,    a);
    chk("cwr_b0_data", phy_wr_data, d0);
    chk("cwr_b0_be",   phy_wr_be,   b0);
    tick();
    chk("cwr_b1_en",   phy_wr_en,   0);
    chk("cwr_b1_data", phy_wr_data, d1);
    chk("cwr_b1_be",   phy_wr_be,   b1);
  endtask

  task automatic cpu_read(input logic [21:0] a);
    cpu_addr = a; cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    chk("crd_n1_idle", phy_rd_en, 0);
    tick();
    chk("crd_en",   phy_rd_en, 1);
    chk("crd_addr", phy_addr,  a);
    q.push_back(1'b0);
    tick();
    chk("crd_pulse", phy_rd_en, 0);
  endtask

  task automatic app_write(input logic [21:0] a, input logic [71:0] d, input logic [7:0] be);
    app_addr = a; app_wr_data = d; app_wr_be = be; app_cmd_we = 1'b1; app_cmd_valid = 1'b1;
    #1;
    chk("awr_ready", app_cmd_ready, 1);
    tick();
    app_cmd_valid = 1'b0;
    chk("awr_b0_en",   phy_wr_en,   1);
    chk("awr_addr",    phy_addr,    a);
    chk("awr_b0_data", phy_wr_data, d[35:0]);
    chk("awr_b0_be",   phy_wr_be,   be[3:0]);
    tick();
    chk("awr_b1_en",   phy_wr_en,   0);
    chk("awr_b1_data", phy_wr_data, d[71:36]);
    chk("awr_b1_be",   phy_wr_be,   be[7:4]);
  endtask

  task automatic app_read(input logic [21:0] a);
    app_addr = a; app_cmd_we = 1'b0; app_cmd_valid = 1'b1;
    #1;
    chk("ard_ready", app_cmd_ready, 1);
    tick();
    app_cmd_valid = 1'b0;
    chk("ard_en",   phy_rd_en, 1);
    chk("ard_addr", phy_addr,  a);
    q.push_back(1'b1);
    tick();
  endtask

  task automatic ret(input logic [35:0] b0, input logic [35:0] b1);
    logic orphan;
    logic to_app;
    orphan = (q.size() == 0);
    to_app = 1'b0;
    if (!orphan) to_app = q.pop_front();
    phy_rd_dvld = 1'b1; phy_rd_data = b0;
    tick();
    phy_rd_dvld = 1'b0; phy_rd_data = b1;
    chk("ret_cpu_dvld_b0", cpu_rd_dvld, !orphan && !to_app);
    if (!orphan && !to_app) chk("ret_cpu_data_b0", cpu_rd_data, b0);
    chk("ret_app_dvld_early", app_rd_dvld, 0);
    tick();
    phy_rd_data = rnd36();
    chk("ret_cpu_dvld_b1", cpu_rd_dvld, 0);
    if (!orphan && !to_app) chk("ret_cpu_data_b1", cpu_rd_data, b1);
    chk("ret_app_dvld", app_rd_dvld, !orphan && to_app);
    if (!orphan && to_app) chk("ret_app_data", app_rd_data, {b1, b0});
    if (orphan) chk("ret_orphan", rd_orphan, 1);
  endtask

  initial begin
    logic        exp_cpu;
    logic        last_cpu;
    int          cpu_n;
    logic [21:0] a;

    qdr_rst_n_i = 1'b1;
    cpu_addr = '0; cpu_wr_en = 1'b0; cpu_wr_data = '0; cpu_wr_be = '0; cpu_rd_en = 1'b0;
    app_cmd_valid = 1'b1; app_cmd_we = 1'b1; app_addr = '0; app_wr_data = '0; app_wr_be = '0;
    phy_rdy = 1'b1; phy_rd_data = '0; phy_rd_dvld = 1'b0; clr_flags = 1'b0;
    #1 qdr_rst_n_i = 1'b0;
    #2 chk_zero("reset");
    do_reset();

    // Directed CPU write and app read with the documented patterns.
    cpu_write(22'h15A5A5, 36'h123456789, 36'hFEDCBA987, 4'hF, 4'h3);
    app_read(22'h3FFFFF);
    ret(36'hAAAAAAAAA, 36'h555555555);

    // Randomized mix of all four command kinds with interleaved returns.
    for (int i = 0; i < 24; i++) begin
      a = 22'($urandom);
      case ($urandom_range(0, 3))
        0: cpu_read(a);
        1: cpu_write(a, rnd36(), rnd36(), 4'($urandom), 4'($urandom));
        2: app_read(a);
        default: app_write(a, {rnd36(), rnd36()}, 8'($urandom));
      endcase
      if (q.size() > 0 && $urandom_range(0, 1) == 1) ret(rnd36(), rnd36());
    end
    while (q.size() > 0) ret(rnd36(), rnd36());

    // Overflow: second strobe while the hold is full is dropped and sticks until cleared.
    phy_rdy = 1'b0;
    cpu_addr = 22'h0ABCDE; cpu_rd_en = 1'b1;
    tick();
    chk("ovf_not_yet", cpu_overflow, 0);
    cpu_addr = 22'h123456;
    tick();
    cpu_rd_en = 1'b0;
    chk("ovf_set", cpu_overflow, 1);
    chk("ovf_no_grant_rdy0", phy_rd_en, 0);
    tick();
    chk("ovf_sticky", cpu_overflow, 1);
    phy_rdy = 1'b1;
    tick();
    chk("ovf_grant_en", phy_rd_en, 1);
    chk("ovf_grant_addr", phy_addr, 22'h0ABCDE);
    q.push_back(1'b0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_cleared", cpu_overflow, 0);
    ret(rnd36(), rnd36());

    // Tag FIFO full: 16 outstanding reads stall the 17th; one return frees it.
    do_reset();
    for (int i = 0; i < 16; i++) app_read(22'($urandom));
    app_addr = 22'h2AAAAA; app_cmd_we = 1'b0; app_cmd_valid = 1'b1;
    #1;
    chk("full_rd_stall", app_cmd_ready, 0);
    app_cmd_we = 1'b1;
    #1;
    chk("full_wr_ok", app_cmd_ready, 1);
    app_cmd_we = 1'b0;
    #1;
    tick();
    chk("full_no_issue", phy_rd_en, 0);
    chk("full_still_stall", app_cmd_ready, 0);
    begin
      logic [35:0] b0, b1;
      b0 = rnd36(); b1 = rnd36();
      void'(q.pop_front());
      phy_rd_dvld = 1'b1; phy_rd_data = b0;
      tick();
      phy_rd_dvld = 1'b0; phy_rd_data = b1;
      #1;
      chk("full_freed_ready", app_cmd_ready, 1);
      tick();
      app_cmd_valid = 1'b0;
      q.push_back(1'b1);
      chk("full_17th_en", phy_rd_en, 1);
      chk("full_17th_addr", phy_addr, 22'h2AAAAA);
      chk("full_ret_dvld", app_rd_dvld, 1);
      chk("full_ret_data", app_rd_data, {b1, b0});
      tick();
    end
    while (q.size() > 0) ret(rnd36(), rnd36());

    // Arbitration: both requesters eligible at every slot for 8 slots.
    do_reset();
    cpu_addr = 22'h00C0DE; cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    app_addr = 22'h1F00D; app_cmd_we = 1'b1; app_wr_data = {rnd36(), rnd36()}; app_wr_be = 8'hFF;
    app_cmd_valid = 1'b1;
    last_cpu = 1'b0;
    cpu_n = 0;
    for (int s = 0; s < 8; s++) begin
      #1;
`ifdef QDR_ARB_RR_EN
      exp_cpu = !last_cpu;
`else
      exp_cpu = 1'b1;
`endif
      chk("arb_ready", app_cmd_ready, !exp_cpu);
      tick();
      chk("arb_cpu_grant", phy_rd_en, exp_cpu);
      chk("arb_app_grant", phy_wr_en, !exp_cpu);
      if (exp_cpu) begin
        cpu_n++;
        cpu_rd_en = 1'b1;
      end else begin
        app_wr_data = {rnd36(), rnd36()};
      end
      last_cpu = exp_cpu;
      tick();
      cpu_rd_en = 1'b0;
    end
    app_cmd_valid = 1'b0;
`ifdef QDR_ARB_RR_EN
    chk("arb_cpu_total", 32'(cpu_n), 4);
`else
    chk("arb_cpu_total", 32'(cpu_n), 8);
`endif
    chk("arb_no_overflow", cpu_overflow, 0);

    // Async reset between write beat 0 and beat 1, then an orphan return.
    do_reset();
    app_addr = 22'h155555; app_wr_data = {rnd36(), rnd36()}; app_wr_be = 8'hA5;
    app_cmd_we = 1'b1; app_cmd_valid = 1'b1;
    tick();
    chk("rstmid_b0", phy_wr_en, 1);
    #2 qdr_rst_n_i = 1'b0;
    #1 chk_zero("rstmid");
    app_cmd_valid = 1'b0;
    tick();
    chk("rstmid_no_b1_data", phy_wr_data, 0);
    qdr_rst_n_i = 1'b1;
    q.delete();
    tick();
    chk("rstmid_idle_data", phy_wr_data, 0);
    chk("rstmid_idle_en", phy_wr_en, 0);
    ret(rnd36(), rnd36());
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("orphan_cleared", rd_orphan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
